// File: rtl/nbit_decoder_pipe_pkg.sv
// Shared types and helpers for the N-to-2^N write-enable decoder.
// Package dec_pkg; the pipe top honours the REG0_MASK_EN build macro.
package dec_pkg;

   localparam int DEC_SEL_W_DEF = 5;
   localparam int DEC_CNT_W_DEF = 16;
   localparam int DEC_SEL_W_MAX = 8;
   localparam int DEC_OH_MAX    = 1 << DEC_SEL_W_MAX;

   function automatic logic [DEC_OH_MAX-1:0] onehot_of(
      input logic [DEC_SEL_W_MAX-1:0] sel,
      input logic                     act
   );
      logic [DEC_OH_MAX-1:0] v;
      v      = '0;
      v[sel] = act;
      return v;
   endfunction

endpackage

// File: rtl/nbit_decoder_pipe_if.sv
// Valid/ready bundle for the decoder pipe: select/enable in, one-hot out.
// master = upstream+downstream side, slave = decoder side.
interface nbit_decoder_pipe_if
   import dec_pkg::*;
#(
   parameter int SEL_W = DEC_SEL_W_DEF,
   parameter int CNT_W = DEC_CNT_W_DEF
);

   logic                  in_valid;
   logic                  in_ready;
   logic [SEL_W-1:0]      sel;
   logic                  act;
   logic                  out_valid;
   logic                  out_ready;
   logic [2**SEL_W-1:0]   onehot;
   logic [CNT_W-1:0]      dec_count;

   modport master (
      output in_valid, sel, act, out_ready,
      input  in_ready, out_valid, onehot, dec_count
   );

   modport slave (
      input  in_valid, sel, act, out_ready,
      output in_ready, out_valid, onehot, dec_count
   );

endinterface

// File: rtl/nbit_decoder_pipe_onehot_core.sv
// Combinational SEL_W -> 2**SEL_W decode, built as a tree of 2-bit stages.
// The top two select bits gate four narrower sub-decoders.
module onehot_core
   import dec_pkg::*;
#(
   parameter int SEL_W = DEC_SEL_W_DEF
) (
   input  logic [SEL_W-1:0]    sel,
   input  logic                act,
   output logic [2**SEL_W-1:0] onehot
);

   if (SEL_W <= 2) begin : g_leaf
      localparam logic [DEC_OH_MAX-1:0] ONE = DEC_OH_MAX'(1);
      logic [DEC_SEL_W_MAX-1:0] sel_x;
      assign sel_x = DEC_SEL_W_MAX'(sel);
      for (genvar i = 0; i < 2**SEL_W; i++) begin : g_bit
         assign onehot[i] = |(onehot_of(sel_x, act) & (ONE << i));
      end
   end else begin : g_tree
      localparam int SUB_W = SEL_W - 2;
      localparam int SUB_N = 2**SUB_W;
      logic [3:0] en;

      onehot_core #(.SEL_W(2)) u_hi (
         .sel    (sel[SEL_W-1 -: 2]),
         .act    (act),
         .onehot (en)
      );

      for (genvar j = 0; j < 4; j++) begin : g_sub
         onehot_core #(.SEL_W(SUB_W)) u_lo (
            .sel    (sel[SUB_W-1:0]),
            .act    (en[j]),
            .onehot (onehot[j*SUB_N +: SUB_N])
         );
      end
   end

endmodule

// File: rtl/nbit_decoder_pipe.sv
// Registered one-hot write-enable decoder with a 2-entry skid pipeline.
// Macro REG0_MASK_EN: when defined, onehot[0] is forced low.
module nbit_decoder_pipe
   import dec_pkg::*;
#(
   parameter int SEL_W = DEC_SEL_W_DEF,
   parameter int CNT_W = DEC_CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   nbit_decoder_pipe_if.slave  bus
);

   localparam int OH_W = 2**SEL_W;

   logic [OH_W-1:0]  core_oh;
   logic [OH_W-1:0]  dec;
   logic [OH_W-1:0]  main_q;
   logic             main_v;
   logic [OH_W-1:0]  skid_q;
   logic             skid_v;
   logic [CNT_W-1:0] cnt_q;
   logic             accept;
   logic             main_free;

   onehot_core #(.SEL_W(SEL_W)) u_core (
      .sel    (bus.sel),
      .act    (bus.act),
      .onehot (core_oh)
   );

`ifdef REG0_MASK_EN
   assign dec = core_oh & ~OH_W'(1);
`else
   assign dec = core_oh;
`endif

   assign accept    = bus.in_valid && !skid_v;
   assign main_free = !main_v || bus.out_ready;

   assign bus.in_ready  = !skid_v;
   assign bus.out_valid = main_v;
   assign bus.onehot    = main_q;
   assign bus.dec_count = cnt_q;

   // main/skid steering: skid refills main first, stalls park new data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q <= '0;
         main_v <= 1'b0;
         skid_q <= '0;
         skid_v <= 1'b0;
      end else if (main_free) begin
         if (skid_v) begin
            main_q <= skid_q;
            main_v <= 1'b1;
            skid_v <= 1'b0;
         end else if (accept) begin
            main_q <= dec;
            main_v <= 1'b1;
         end else begin
            main_v <= 1'b0;
         end
      end else if (accept) begin
         skid_q <= dec;
         skid_v <= 1'b1;
      end
   end

   // wrap-around count of accepted transactions
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_nbit_decoder_pipe.sv
// Self-checking bench for nbit_decoder_pipe: directed scenarios plus
// a queue scoreboard fed at accept and drained at output transfer.
module tb_nbit_decoder_pipe;
   import dec_pkg::*;

   localparam int SW = 5;
   localparam int W  = 32;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nbit_decoder_pipe_if #(.SEL_W(SW), .CNT_W(CW)) bus ();
   nbit_decoder_pipe_if #(.SEL_W(SW), .CNT_W(4))  bus4 ();

   nbit_decoder_pipe #(.SEL_W(SW), .CNT_W(CW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   nbit_decoder_pipe #(.SEL_W(SW), .CNT_W(4)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   int           checks = 0;
   int           errors = 0;
   int           acc_cnt = 0;
   logic [W-1:0] exp_q[$];
   logic         stalled = 1'b0;
   logic [W-1:0] held = '0;

`ifdef REG0_MASK_EN
   localparam logic [W-1:0] EXP_SEL0 = 32'h0000_0000;
`else
   localparam logic [W-1:0] EXP_SEL0 = 32'h0000_0001;
`endif

   function automatic logic [W-1:0] model(input logic [SW-1:0] s,
                                          input logic a);
      logic [DEC_OH_MAX-1:0] f;
      logic [W-1:0]          m;
      f = onehot_of(8'(s), a);
      m = f[W-1:0];
`ifdef REG0_MASK_EN
      m[0] = 1'b0;
`endif
      return m;
   endfunction

   // scoreboard: stability, output pop, accept push
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (rst) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.onehot !== held) begin
               errors++;
               $display("FAIL stable: valid=%b onehot=%h want valid=1 onehot=%h",
                        bus.out_valid, bus.onehot, held);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_extra: onehot=%h with empty queue", bus.onehot);
            end else begin
               e = exp_q.pop_front();
               if (bus.onehot !== e) begin
                  errors++;
                  $display("FAIL sb_data: got %h want %h", bus.onehot, e);
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.sel, bus.act));
            acc_cnt++;
         end
         stalled = bus.out_valid && !bus.out_ready;
         held    = bus.onehot;
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus4.in_valid = 1'b0;
      stalled = 1'b0;
      #4;
      exp_q.delete();
      acc_cnt = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic send(input logic [SW-1:0] s, input logic a);
      int  n;
      logic ok;
      n  = 0;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.sel      = s;
      bus.act      = a;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = bus.in_ready;
         n++;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready=%b want 1", bus.in_ready);
      end
   endtask

   task automatic test_reset();
      #2;
      checks += 3;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_valid: got %b want 0", bus.out_valid);
      end
      if (bus.onehot !== '0) begin
         errors++; $display("FAIL rst_onehot: got %h want 0", bus.onehot);
      end
      if (bus.dec_count !== '0) begin
         errors++; $display("FAIL rst_count: got %0d want 0", bus.dec_count);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL rst_ready: got %b want 1", bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      send(5'd4, 1'b1);
      send(5'd6, 1'b1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL full_ready: got %b want 0", bus.in_ready);
      end
      #2;
      rst = 1'b1;
      stalled = 1'b0;
      #1;
      checks += 3;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL mid_rst_valid: got %b want 0", bus.out_valid);
      end
      if (bus.onehot !== '0) begin
         errors++; $display("FAIL mid_rst_onehot: got %h want 0", bus.onehot);
      end
      if (bus.dec_count !== '0) begin
         errors++; $display("FAIL mid_rst_count: got %0d want 0", bus.dec_count);
      end
      exp_q.delete();
      acc_cnt = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks += 2;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL mid_rst_ready: got %b want 1", bus.in_ready);
      end
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL mid_rst_partial: got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_stream();
      do_reset();
      bus.out_ready = 1'b1;
      for (int s = 0; s < 32; s++) send(5'(s), 1'b1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks += 2;
      if (bus.dec_count !== 16'd32) begin
         errors++; $display("FAIL stream_count: got %0d want 32", bus.dec_count);
      end
      if (bus.onehot !== 32'h8000_0000) begin
         errors++; $display("FAIL stream_last: got %h want 80000000", bus.onehot);
      end
      @(posedge clk);
      #1;
      send(5'd3, 1'b1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks += 3;
      if (bus.onehot !== 32'h0000_0008) begin
         errors++; $display("FAIL sel3: got %h want 00000008", bus.onehot);
      end
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL sel3_valid: got %b want 1", bus.out_valid);
      end
      if (bus.dec_count !== 16'd33) begin
         errors++; $display("FAIL sel3_count: got %0d want 33", bus.dec_count);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back_stall();
      do_reset();
      bus.out_ready = 1'b0;
      send(5'd7, 1'b1);
      send(5'd9, 1'b1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks += 3;
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL stall_valid: got %b want 1", bus.out_valid);
      end
      if (bus.onehot !== 32'h0000_0080) begin
         errors++; $display("FAIL stall_main: got %h want 00000080", bus.onehot);
      end
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL stall_ready: got %b want 0", bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks += 2;
      if (bus.onehot !== 32'h0000_0080) begin
         errors++; $display("FAIL drain1: got %h want 00000080", bus.onehot);
      end
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL drain1_ready: got %b want 0", bus.in_ready);
      end
      @(negedge clk);
      checks += 3;
      if (bus.onehot !== 32'h0000_0200) begin
         errors++; $display("FAIL drain2: got %h want 00000200", bus.onehot);
      end
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL drain2_valid: got %b want 1", bus.out_valid);
      end
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL drain2_ready: got %b want 1", bus.in_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL drain_empty: got %b want 0", bus.out_valid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_act0();
      do_reset();
      send(5'd31, 1'b0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks += 3;
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL act0_valid: got %b want 1", bus.out_valid);
      end
      if (bus.onehot !== 32'h0) begin
         errors++; $display("FAIL act0_onehot: got %h want 0", bus.onehot);
      end
      if (bus.dec_count !== 16'd1) begin
         errors++; $display("FAIL act0_count: got %0d want 1", bus.dec_count);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reg0();
      do_reset();
      send(5'd0, 1'b1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks += 3;
      if (bus.onehot !== EXP_SEL0) begin
         errors++; $display("FAIL reg0: got %h want %h", bus.onehot, EXP_SEL0);
      end
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL reg0_valid: got %b want 1", bus.out_valid);
      end
      if (bus.dec_count !== 16'd1) begin
         errors++; $display("FAIL reg0_count: got %0d want 1", bus.dec_count);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_wrap();
      int n;
      int cyc;
      do_reset();
      bus4.out_ready = 1'b1;
      bus4.act       = 1'b1;
      bus4.in_valid  = 1'b1;
      n   = 0;
      cyc = 0;
      while (n < 17 && cyc < 60) begin
         bus4.sel = 5'(n);
         @(negedge clk);
         if (bus4.in_ready) n++;
         cyc++;
         @(posedge clk);
         #1;
      end
      bus4.in_valid = 1'b0;
      @(negedge clk);
      checks += 3;
      if (n != 17) begin
         errors++; $display("FAIL wrap_accepts: got %0d want 17", n);
      end
      if (bus4.dec_count !== 4'd1) begin
         errors++; $display("FAIL wrap_count: got %0d want 1", bus4.dec_count);
      end
      if (bus4.onehot !== 32'h0001_0000) begin
         errors++; $display("FAIL wrap_last: got %h want 00010000", bus4.onehot);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_stress();
      int n;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.sel       = 5'($urandom_range(0, 31));
         bus.act       = ($urandom_range(0, 7) != 0);
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checks += 3;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL stress_left: got %0d pending want 0", exp_q.size());
      end
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL stress_idle: got %b want 0", bus.out_valid);
      end
      if (bus.dec_count !== 16'(acc_cnt)) begin
         errors++; $display("FAIL stress_count: got %0d want %0d",
                            bus.dec_count, 16'(acc_cnt));
      end
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.sel        = '0;
      bus.act        = 1'b0;
      bus.out_ready  = 1'b1;
      bus4.in_valid  = 1'b0;
      bus4.sel       = '0;
      bus4.act       = 1'b0;
      bus4.out_ready = 1'b1;
      test_reset();
      test_stream();
      test_back_to_back_stall();
      test_act0();
      test_reg0();
      test_wrap();
      test_stress();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
